// File: rtl/mult_div_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_if
//  Description : Request/result bundle for the iterative multiply/divide unit.
//                master = requester side, slave = the arithmetic unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mult_div_if #(
    parameter int N = 32
);
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] inA;
    logic [N-1:0] inB;
    logic         hi_wen;
    logic         lo_wen;
    logic [N-1:0] wd;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [N-1:0] hi;
    logic [N-1:0] lo;

    modport master (
        output start, op, inA, inB, hi_wen, lo_wen, wd,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, inA, inB, hi_wen, lo_wen, wd,
        output busy, done, div_zero, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result
//                registers. One bit per cycle on operand magnitudes, followed
//                by a single sign-correction cycle. N must be even and >= 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int N = 32
) (
    input  wire logic  clock,
    input  wire logic  reset,
    mult_div_if.slave  bus
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           is_div_q, is_div_d;
    logic           neg_quo_q, neg_quo_d;   // product / quotient must be negated
    logic           neg_rem_q, neg_rem_d;   // remainder must be negated
    logic [N-1:0]   mag_q, mag_d;           // multiplicand or divisor magnitude
    logic [2*N-1:0] acc_q, acc_d;           // {upper, lower} working register
    logic [N-1:0]   hi_q, hi_d;
    logic [N-1:0]   lo_q, lo_d;
    logic           div_zero_q, div_zero_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           accept;
    logic           a_neg, b_neg;
    logic [N-1:0]   a_mag, b_mag;
    logic [N-1:0]   rem, quo;
    logic [N:0]     mul_sum;
    logic [N:0]     trial;
    logic [N+1:0]   diff;
    logic [2*N-1:0] acc_step;
    logic [2*N-1:0] prod_fix;
    logic [N-1:0]   quo_fix, rem_fix;

    // Operand conditioning and one iteration step of shift-add / restoring divide
    always_comb begin
        accept   = bus.start && (state_q == S_IDLE || state_q == S_DONE);
        a_neg    = ~bus.op[0] & bus.inA[N-1];
        b_neg    = ~bus.op[0] & bus.inB[N-1];
        a_mag    = a_neg ? -bus.inA : bus.inA;
        b_mag    = b_neg ? -bus.inB : bus.inB;

        rem      = acc_q[2*N-1:N];
        quo      = acc_q[N-1:0];
        mul_sum  = {1'b0, rem} + {1'b0, mag_q};
        trial    = {rem, quo[N-1]};
        diff     = {1'b0, trial} - {2'b00, mag_q};

        if (is_div_q) begin
            // Borrow out means the trial subtraction failed: keep the shifted value
            acc_step = diff[N+1] ? {trial[N-1:0], quo[N-2:0], 1'b0}
                                 : {diff[N-1:0],  quo[N-2:0], 1'b1};
        end else begin
            acc_step = quo[0] ? {mul_sum, quo[N-1:1]}
                              : {1'b0, rem, quo[N-1:1]};
        end

        prod_fix = neg_quo_q ? -acc_q : acc_q;
        quo_fix  = neg_quo_q ? -quo   : quo;
        rem_fix  = neg_rem_q ? -rem   : rem;
    end

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        mag_d      = mag_q;
        acc_d      = acc_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    cnt_d    = '0;
                    is_div_d = bus.op[1];
                    if (bus.op[1] && (bus.inB == '0)) begin
                        // Divide by zero resolves immediately without iterating
                        state_d    = S_DONE;
                        hi_d       = bus.inA;
                        lo_d       = '1;
                        div_zero_d = 1'b1;
                    end else begin
                        state_d   = S_RUN;
                        mag_d     = bus.op[1] ? b_mag : a_mag;
                        acc_d     = {{N{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                    end
                end else begin
                    state_d = S_IDLE;
                    if (bus.hi_wen) hi_d = bus.wd;
                    if (bus.lo_wen) lo_d = bus.wd;
                end
            end
            S_RUN: begin
                acc_d = acc_step;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_FIX;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FIX: begin
                // Results become visible only here, after sign correction
                state_d    = S_DONE;
                div_zero_d = 1'b0;
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*N-1:N];
                    lo_d = prod_fix[N-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    // State and output registers with asynchronous active-low clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            mag_q      <= '0;
            acc_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            mag_q      <= mag_d;
            acc_q      <= acc_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_div_unit
//  Description : Self-checking bench for mult_div_unit (N = 32). An abstract
//                timing/arithmetic model predicts every output each cycle;
//                literal expectations pin the model on key vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;
    localparam int N = 32;

    logic clock;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;
    bit   cmp_en  = 1'b0;

    mult_div_if #(.N(N)) bus ();

    mult_div_unit #(.N(N)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Arithmetic reference: returns {div_zero, hi, lo}
    function automatic logic [64:0] ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp, sq, sr;
        longint unsigned up;
        logic [64:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        case (o)
            2'd0: begin sp = sa * sb; r = {1'b0, sp[63:0]}; end
            2'd1: begin up = {32'd0, a} * {32'd0, b}; r = {1'b0, up[63:0]}; end
            default: begin
                if (b == 32'd0) begin
                    r = {1'b1, a, 32'hFFFF_FFFF};
                end else if (o == 2'd2) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    r  = {1'b0, sr[31:0], sq[31:0]};
                end else begin
                    r = {1'b0, a % b, a / b};
                end
            end
        endcase
        return r;
    endfunction

    // Cycle-level expectation: an accepted op completes N+1 edges later
    int          m_pending;
    logic        m_busy, m_done, m_dz;
    logic [31:0] m_hi, m_lo;
    logic [64:0] m_res;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_pending = 0; m_busy = 0; m_done = 0; m_dz = 0; m_hi = 0; m_lo = 0; m_res = '0;
        end else begin
            m_done = 0;
            if (m_pending > 0) begin
                m_pending--;
                if (m_pending == 0) begin
                    {m_dz, m_hi, m_lo} = m_res;
                    m_done = 1;
                    m_busy = 0;
                end
            end else if (bus.start) begin
                m_res = ref_op(bus.op, bus.inA, bus.inB);
                if (bus.op[1] && bus.inB == 32'd0) begin
                    {m_dz, m_hi, m_lo} = m_res;
                    m_done = 1;
                end else begin
                    m_pending = N + 1;
                    m_busy    = 1;
                end
            end else begin
                if (bus.hi_wen) m_hi = bus.wd;
                if (bus.lo_wen) m_lo = bus.wd;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clock) begin
        if (cmp_en) begin
            check("cyc_busy", {63'd0, bus.busy}, {63'd0, m_busy});
            check("cyc_done", {63'd0, bus.done}, {63'd0, m_done});
            check("cyc_dz",   {63'd0, bus.div_zero}, {63'd0, m_dz});
            check("cyc_hi",   {32'd0, bus.hi}, {32'd0, m_hi});
            check("cyc_lo",   {32'd0, bus.lo}, {32'd0, m_lo});
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.done && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, output int lat);
        bus.start = 1'b1; bus.op = o; bus.inA = a; bus.inB = b;
        tick();
        bus.start = 1'b0;
        wait_done(lat);
    endtask

    task automatic check_res(input string name, input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
        check({name, "_hi"}, {32'd0, bus.hi}, {32'd0, ehi});
        check({name, "_lo"}, {32'd0, bus.lo}, {32'd0, elo});
        check({name, "_dz"}, {63'd0, bus.div_zero}, {63'd0, edz});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        reset = 1'b0;
        bus.start = 0; bus.op = 0; bus.inA = 0; bus.inB = 0;
        bus.hi_wen = 0; bus.lo_wen = 0; bus.wd = 0;
        #1 cmp_en = 1'b1;
        repeat (3) tick();
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check_res("rst", 32'd0, 32'd0, 1'b0);

        // First edge after reset release accepts the request
        reset = 1'b1;
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        check("multu_max_lat", 64'(lat), 64'd33);
        check_res("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);

        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, lat);
        check_res("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);

        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, lat);
        check_res("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

        run_op(2'd3, 32'd100, 32'd0, lat);
        check("divz_lat", 64'(lat), 64'd0);
        check_res("divz", 32'd100, 32'hFFFF_FFFF, 1'b1);

        run_op(2'd1, 32'd2, 32'd3, lat);
        check_res("multu_small", 32'd0, 32'd6, 1'b0);

        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        check_res("div_ovf", 32'd0, 32'h8000_0000, 1'b0);

        run_op(2'd0, 32'h8000_0000, 32'h8000_0000, lat);
        check_res("mult_minmin", 32'h4000_0000, 32'd0, 1'b0);

        run_op(2'd2, 32'd7, 32'hFFFF_FFFE, lat);
        check_res("div_negb", 32'd1, 32'hFFFF_FFFD, 1'b0);

        run_op(2'd3, 32'hFFFF_FFFF, 32'd7, lat);
        check_res("divu_big", 32'd3, 32'h2492_4924, 1'b0);

        // From DONE: div-by-zero accepted; simultaneous hi_wen must be ignored
        bus.hi_wen = 1'b1; bus.wd = 32'h5555;
        run_op(2'd3, 32'd100, 32'd0, lat);
        bus.hi_wen = 1'b0;
        check_res("divz_done", 32'd100, 32'hFFFF_FFFF, 1'b1);
        tick();

        // start and hi_wen mid-RUN are ignored
        bus.start = 1'b1; bus.op = 2'd1; bus.inA = 32'd5; bus.inB = 32'd7;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        bus.start = 1'b1; bus.op = 2'd0; bus.inA = 32'd9; bus.inB = 32'd9;
        bus.hi_wen = 1'b1; bus.wd = 32'h1234;
        tick();
        bus.start = 1'b0; bus.hi_wen = 1'b0;
        wait_done(lat);
        check_res("midrun", 32'd0, 32'd35, 1'b0);
        tick();
        bus.hi_wen = 1'b1;
        tick();
        bus.hi_wen = 1'b0;
        check_res("mthi", 32'h1234, 32'd35, 1'b0);
        bus.lo_wen = 1'b1; bus.wd = 32'hABCD;
        tick();
        bus.lo_wen = 1'b0;
        check_res("mtlo", 32'h1234, 32'hABCD, 1'b0);

        // Reset in the middle of RUN abandons the operation at once
        bus.start = 1'b1; bus.op = 2'd1; bus.inA = 32'hFFFF; bus.inB = 32'hFFFF;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        reset = 1'b0;
        #1;
        check("rstmid_busy", {63'd0, bus.busy}, 64'd0);
        check("rstmid_done", {63'd0, bus.done}, 64'd0);
        check_res("rstmid", 32'd0, 32'd0, 1'b0);
        repeat (2) tick();
        reset = 1'b1;
        run_op(2'd1, 32'd5, 32'd6, lat);
        check("after_rst_lat", 64'(lat), 64'd33);
        check_res("after_rst", 32'd0, 32'd30, 1'b0);
        repeat (3) tick();

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
